// File: rtl/alu_add_sequencer_if.sv
// Request/result bus of the chunked 64-bit add/sub sequencer.
// Two requesters with valid/ready handshakes, one result channel.
interface alu_add_sequencer_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [63:0] req0_a;
   logic [63:0] req0_b;
   logic        req0_sub;
   logic        req1_valid;
   logic        req1_ready;
   logic [63:0] req1_a;
   logic [63:0] req1_b;
   logic        req1_sub;
   logic        res_valid;
   logic        res_ready;
   logic        res_id;
   logic [63:0] res_sum;
   logic        res_carry;
   logic        res_overflow;

   // requesters + result consumer side
   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      output req1_valid, req1_a, req1_b, req1_sub,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_id, res_sum, res_carry, res_overflow
   );

   // sequencer side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      input  req1_valid, req1_a, req1_b, req1_sub,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_id, res_sum, res_carry, res_overflow
   );
endinterface

// File: rtl/alu_add_sequencer.sv
// 64-bit add/sub built from a CHUNK_W-wide adder reused over N = 64/CHUNK_W
// cycles. Two requesters share it through a round-robin arbiter; one
// operation in flight, result held until the consumer takes it.
module alu_add_sequencer #(
   parameter int CHUNK_W = 16
) (
   input logic                clk,
   input logic                rst,
   alu_add_sequencer_if.slave bus
);

   localparam int N     = 64 / CHUNK_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic [63:0]        a_q, a_d;
   logic [63:0]        b_q, b_d;        // already inverted for subtract
   logic [63:0]        acc_q, acc_d;    // partial sum, hidden from res_sum until done
   logic               id_q, id_d;
   logic               prio_q, prio_d;  // 1: req1 has priority
   logic               res_valid_q, res_valid_d;
   logic               res_id_q, res_id_d;
   logic [63:0]        res_sum_q, res_sum_d;
   logic               res_carry_q, res_carry_d;
   logic               res_overflow_q, res_overflow_d;

   logic               gnt0, gnt1;
   logic               sel_sub;
   int                 idx;
   logic [CHUNK_W-1:0] a_chunk, b_chunk;
   logic [CHUNK_W:0]   chunk_sum;

   // Round-robin grant; only offered in IDLE and never while reset is high.
   assign gnt0 = (state_q == IDLE) && !rst && bus.req0_valid && (!bus.req1_valid || !prio_q);
   assign gnt1 = (state_q == IDLE) && !rst && bus.req1_valid && (!bus.req0_valid || prio_q);

   assign bus.req0_ready   = gnt0;
   assign bus.req1_ready   = gnt1;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_id       = res_id_q;
   assign bus.res_sum      = res_sum_q;
   assign bus.res_carry    = res_carry_q;
   assign bus.res_overflow = res_overflow_q;

   // Next-state: accept, run one chunk per cycle, publish, wait for consumer.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      carry_d        = carry_q;
      a_d            = a_q;
      b_d            = b_q;
      acc_d          = acc_q;
      id_d           = id_q;
      prio_d         = prio_q;
      res_valid_d    = res_valid_q;
      res_id_d       = res_id_q;
      res_sum_d      = res_sum_q;
      res_carry_d    = res_carry_q;
      res_overflow_d = res_overflow_q;
      sel_sub        = gnt1 ? bus.req1_sub : bus.req0_sub;
      idx            = int'(cnt_q) * CHUNK_W;
      a_chunk        = a_q[idx +: CHUNK_W];
      b_chunk        = b_q[idx +: CHUNK_W];
      chunk_sum      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_W{1'b0}}, carry_q};

      case (state_q)
         IDLE: begin
            if (gnt0 || gnt1) begin
               a_d     = gnt1 ? bus.req1_a : bus.req0_a;
               b_d     = (gnt1 ? bus.req1_b : bus.req0_b) ^ {64{sel_sub}};
               carry_d = sel_sub;
               id_d    = gnt1;
               // Updating at grant is equivalent to updating on result
               // release since nothing else can be granted in between.
               prio_d  = gnt0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[idx +: CHUNK_W] = chunk_sum[CHUNK_W-1:0];
            carry_d               = chunk_sum[CHUNK_W];
            cnt_d                 = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
               cnt_d          = '0;
               state_d        = DONE;
               res_valid_d    = 1'b1;
               res_id_d       = id_q;
               res_sum_d      = acc_d;
               res_carry_d    = chunk_sum[CHUNK_W];
               res_overflow_d = (a_q[63] == b_q[63]) && (acc_d[63] != a_q[63]);
            end
         end
         DONE: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         carry_q        <= 1'b0;
         a_q            <= '0;
         b_q            <= '0;
         acc_q          <= '0;
         id_q           <= 1'b0;
         prio_q         <= 1'b0;
         res_valid_q    <= 1'b0;
         res_id_q       <= 1'b0;
         res_sum_q      <= '0;
         res_carry_q    <= 1'b0;
         res_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         carry_q        <= carry_d;
         a_q            <= a_d;
         b_q            <= b_d;
         acc_q          <= acc_d;
         id_q           <= id_d;
         prio_q         <= prio_d;
         res_valid_q    <= res_valid_d;
         res_id_q       <= res_id_d;
         res_sum_q      <= res_sum_d;
         res_carry_q    <= res_carry_d;
         res_overflow_q <= res_overflow_d;
      end
   end

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Directed bench for alu_add_sequencer with CHUNK_W = 16 (4 run cycles).
module tb_alu_add_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_add_sequencer_if bus ();

   alu_add_sequencer #(.CHUNK_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int cmp  = 0;
   int errs = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for res_valid (bounded); flags any ready seen while busy.
   task automatic wait_res(input string tag, output int lat);
      bit seen;
      lat  = 0;
      seen = 1'b0;
      while (!bus.res_valid && lat < 20) begin
         seen |= bus.req0_ready | bus.req1_ready;
         tick();
         lat++;
      end
      seen |= bus.req0_ready | bus.req1_ready;
      chk({tag, " res_valid"}, 64'(bus.res_valid), 64'd1);
      chk({tag, " busy_ready"}, 64'(seen), 64'd0);
   endtask

   // One operation from a single requester, consumed right after it shows up.
   task automatic run_op(input bit id, input logic [63:0] a, input logic [63:0] b, input bit sub,
                         input logic [63:0] es, input bit ec, input bit eo, input string tag);
      int lat;
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
      end
      #1;
      chk({tag, " grant"}, 64'({bus.req1_ready, bus.req0_ready}), id ? 64'd2 : 64'd1);
      tick();
      // operands scrambled and valid kept high after the handshake
      if (id) begin
         bus.req1_a = 64'hDEAD_BEEF_0BAD_F00D; bus.req1_b = 64'h1234_5678_9ABC_DEF0; bus.req1_sub = ~sub;
      end else begin
         bus.req0_a = 64'hDEAD_BEEF_0BAD_F00D; bus.req0_b = 64'h1234_5678_9ABC_DEF0; bus.req0_sub = ~sub;
      end
      wait_res(tag, lat);
      chk({tag, " latency"}, 64'(lat), 64'd4);
      chk({tag, " id"}, 64'(bus.res_id), 64'(id));
      chk({tag, " sum"}, bus.res_sum, es);
      chk({tag, " carry"}, 64'(bus.res_carry), 64'(ec));
      chk({tag, " ovf"}, 64'(bus.res_overflow), 64'(eo));
      if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk({tag, " released"}, 64'(bus.res_valid), 64'd0);
   endtask

   initial begin
      int  n;
      int  lat;
      bit  both;
      logic [63:0] exp_sum [2];

      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
      bus.res_ready  = 1'b0;
      #1;
      chk("rst ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
      tick();
      tick();
      chk("rst ready held", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
      chk("rst res", {bus.res_sum[61:0], bus.res_valid, bus.res_id}, 64'd0);
      chk("rst res flags", 64'({bus.res_carry, bus.res_overflow, bus.res_sum[63:62]}), 64'd0);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      rst = 1'b0;
      tick();

      // Arithmetic vectors
      run_op(1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, "add carry chain");
      run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "add ovf");
      run_op(1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b1, 1'b0, "add wrap");
      run_op(1'b0, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub borrow");
      run_op(1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sub ovf");

      // Round robin with both requesters always valid
      rst = 1'b1; tick(); rst = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 64'd10;  bus.req0_b = 64'd3; bus.req0_sub = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = 64'd100; bus.req1_b = 64'd1; bus.req1_sub = 1'b1;
      bus.res_ready  = 1'b1;
      exp_sum[0] = 64'd13;
      exp_sum[1] = 64'd99;
      #1;
      both = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
            both |= bus.req0_ready & bus.req1_ready;
            tick();
            n++;
         end
         both |= bus.req0_ready & bus.req1_ready;
         chk("rr grant", 64'({bus.req1_ready, bus.req0_ready}), (k % 2) ? 64'd2 : 64'd1);
         tick();
         wait_res("rr", lat);
         chk("rr id", 64'(bus.res_id), 64'(k % 2));
         chk("rr sum", bus.res_sum, exp_sum[k % 2]);
         tick();
      end
      chk("rr both ready", 64'(both), 64'd0);

      // Result held with consumer stalled; req0 has priority after req1
      bus.res_ready = 1'b0;
      chk("stall grant", 64'({bus.req1_ready, bus.req0_ready}), 64'd1);
      tick();
      wait_res("stall", lat);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("stall hold", {bus.res_sum[59:0], bus.res_valid, bus.res_id, bus.res_carry, bus.res_overflow},
             {60'd13, 1'b1, 1'b0, 1'b0, 1'b0});
         chk("stall ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
      end
      bus.res_ready = 1'b1;
      tick();
      chk("stall release", 64'(bus.res_valid), 64'd0);
      chk("stall next grant", 64'({bus.req1_ready, bus.req0_ready}), 64'd2);
      tick();
      wait_res("after stall", lat);
      chk("after stall id", 64'(bus.res_id), 64'd1);
      chk("after stall sum", bus.res_sum, 64'd99);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      tick();
      bus.res_ready = 1'b0;

      // Reset in RUN cycle 2 discards the operation
      bus.req1_valid = 1'b1; bus.req1_a = 64'd1; bus.req1_b = 64'd1; bus.req1_sub = 1'b0;
      #1;
      chk("abort grant", 64'({bus.req1_ready, bus.req0_ready}), 64'd2);
      tick();
      bus.req1_valid = 1'b0;
      tick();
      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      chk("abort rst ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
      tick();
      chk("abort rst ready idle", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
      chk("abort res", bus.res_sum, 64'd0);
      chk("abort res flags", 64'({bus.res_valid, bus.res_id, bus.res_carry, bus.res_overflow}), 64'd0);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      rst = 1'b0;
      both = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         both |= bus.res_valid;
      end
      chk("abort no result", 64'(both), 64'd0);
      bus.req1_valid = 1'b1; bus.req1_a = 64'd7; bus.req1_b = 64'd7; bus.req1_sub = 1'b0;
      run_op(1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
             64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, "post rst");
      bus.req1_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule

// File: doc/alu_add_sequencer.md
ALU_ADD_SEQUENCER -- requirements
Module: alu_add_sequencer

Interface
REQ-001 SHALL have parameter CHUNK_W, default 16, adder slice width per cycle; legal values 4, 8, 16, 32; N = 64/CHUNK_W cycles per operation.
REQ-002 SHALL have ports, clock and reset first:
  clk           input   1   single clock; all state updates on rising edge
  rst           input   1   synchronous, active-high reset
  req0_valid    input   1   requester 0 has an operation pending
  req0_ready    output  1   requester 0 operation accepted this cycle
  req0_a        input   64  requester 0 operand A
  req0_b        input   64  requester 0 operand B
  req0_sub      input   1   requester 0: 0 = A+B, 1 = A-B
  req1_valid    input   1   requester 1 has an operation pending
  req1_ready    output  1   requester 1 operation accepted this cycle
  req1_a        input   64  requester 1 operand A
  req1_b        input   64  requester 1 operand B
  req1_sub      input   1   requester 1: 0 = A+B, 1 = A-B
  res_valid     output  1   result available
  res_ready     input   1   consumer takes result
  res_id        output  1   requester that owns the result
  res_sum       output  64  result, modulo 2^64
  res_carry     output  1   carry out of bit 63 (sub: 1 = no borrow)
  res_overflow  output  1   two's-complement signed overflow
REQ-003 Clock is clk; reset is rst, synchronous and active-high; no other clock or asynchronous reset.

Function
REQ-004 SHALL implement FSM with states IDLE, RUN, DONE; only one operation in flight.
REQ-005 IDLE: reqX_ready SHALL be high combinationally only for the arbitration winner among asserted reqX_valid; both ready low in RUN, DONE, and while rst high.
REQ-006 Arbitration SHALL be round-robin over 2 requesters: last-granted requester gets lowest priority; after reset req0 has priority.
REQ-007 On handshake (valid & ready), SHALL latch A, B XOR {64{sub}}, carry-in = sub, and requester id; clear chunk counter; go to RUN.
REQ-008 RUN: each cycle k = 0..N-1 SHALL add chunk k (bits k*CHUNK_W+CHUNK_W-1 : k*CHUNK_W) of latched A and B' with carry register, write sum chunk k, store chunk carry-out as next carry-in.
REQ-009 After chunk N-1, SHALL go to DONE with res_valid high; res_carry = final carry; res_overflow = (A[63] == B'[63]) & (sum[63] != A[63]).
REQ-010 Latency: handshake in cycle 0, RUN in cycles 1..N, res_valid first high in cycle N+1 (cycle 5 for CHUNK_W=16).
REQ-011 DONE: res_valid, res_id, res_sum, res_carry, res_overflow SHALL hold stable until res_valid & res_ready; then IDLE next cycle, res_valid low, round-robin pointer updated.
REQ-012 No acceptance during DONE; one IDLE cycle minimum between consecutive results (throughput one op per N+2 cycles).
REQ-013 res_sum/res_carry/res_overflow/res_id SHALL hold last values while res_valid low, except during reset.
REQ-014 reqX_a/b/sub need only be stable in the handshake cycle; later changes SHALL not affect the result.

Reset
REQ-015 While rst high at a clock edge: state to IDLE, counter, carry, all res_* outputs to 0, priority to req0, in-flight operation discarded without a result.
REQ-016 rst asserted in any state, including mid-RUN or DONE with res_ready low, SHALL take effect at the next edge.

Verification
REQ-017 req0 add A=0x0000_0000_FFFF_FFFF, B=1 -> res_sum 0x0000_0001_0000_0000, carry 0, overflow 0, res_id 0, res_valid in cycle 5.
REQ-018 Add A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> sum 0x8000_0000_0000_0000, overflow 1, carry 0; add A=1, B=0xFFFF_FFFF_FFFF_FFFF -> sum 0, carry 1, overflow 0.
REQ-019 Sub A=5, B=7 -> sum 0xFFFF_FFFF_FFFF_FFFE, carry 0, overflow 0; sub A=0x8000_0000_0000_0000, B=1 -> sum 0x7FFF_FFFF_FFFF_FFFF, carry 1, overflow 1.
REQ-020 Both valid held high after reset, res_ready high -> grants alternate req0, req1, req0, req1; res_id 0,1,0,1; never both ready in one cycle.
REQ-021 res_ready low 10 cycles in DONE -> res_valid and all res_* stable, both ready low; res_ready high -> IDLE next cycle, next grant follows.
REQ-022 rst pulsed in RUN cycle 2 -> no result, res_* 0, ready low during rst; new request after rst completes correctly with res_id per req0-first priority.
